// File: rtl/counter_checker_pkg.sv
// Shared types and defaults for the counter stream checker.
package counter_checker_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_LOCK_LEN  = 4;
  localparam int DEF_ERR_CNT_W = 16;
  localparam int LOCK_LEN_MAX  = 15;
  localparam int RUN_W         = 4;   // holds 0..LOCK_LEN_MAX
  localparam int WRAP_CNT_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the clear
// cycle is still counted, so clear+inc leaves the count at 1.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Receiving-end checker for a free-running counter: locks onto the sequence
// and flags every sample that is not previous+1. Optional wrap statistics are
// enabled with the COUNTER_CHECKER_WRAP_EN macro.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOCK_LEN  = DEF_LOCK_LEN,   // 1..LOCK_LEN_MAX
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     value,
  input  logic                 src_reset,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_bad,
  output logic [WIDTH-1:0]     first_exp
`ifdef COUNTER_CHECKER_WRAP_EN
  ,
  output logic [WRAP_CNT_W-1:0] wrap_count
`endif
);

  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   prev;
  logic [WIDTH-1:0]   expected;
  logic [RUN_W-1:0]   run;
  logic [RUN_W-1:0]   run_nxt;
  logic               match;
  logic               err_event;

  assign expected = prev + WIDTH'(1);
  assign match    = (value == expected);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEEK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (src_reset) begin
      state_nxt = SEEK;
    end else begin
      case (state)
        SEEK:    state_nxt = TRAIN;
        TRAIN:   if (match && ((run + RUN_W'(1)) == LOCK_RUN)) state_nxt = LOCKED;
        LOCKED:  state_nxt = LOCKED;
        default: state_nxt = SEEK;
      endcase
    end
  end

  always_comb begin
    run_nxt   = '0;
    err_event = 1'b0;
    if (!src_reset) begin
      if ((state == TRAIN) && match) run_nxt = run + RUN_W'(1);
      if ((state == LOCKED) && !match) err_event = 1'b1;
    end
  end

  assign locked = (state == LOCKED);

  // prev follows the observed value every cycle; SEEK exit is just the first load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev       <= '0;
      run        <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      first_bad  <= '0;
      first_exp  <= '0;
    end else begin
      prev      <= value;
      run       <= run_nxt;
      err_pulse <= err_event;
      if (clear) begin
        err_sticky <= err_event;
        first_bad  <= err_event ? value : '0;
        first_exp  <= err_event ? expected : '0;
      end else if (err_event && !err_sticky) begin
        err_sticky <= 1'b1;
        first_bad  <= value;
        first_exp  <= expected;
      end
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (err_event),
    .count (err_count)
  );

`ifdef COUNTER_CHECKER_WRAP_EN
  logic wrap_inc;

  assign wrap_inc = (state == LOCKED) && !src_reset && match && (prev == '1);

  sat_counter #(.W(WRAP_CNT_W)) u_wrap_count (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (wrap_inc),
    .count (wrap_count)
  );
`endif

endmodule

// File: doc/counter_checker.md
# counter_checker

Stream checker that sits at the receiving end of the free-running 8-bit counter: it samples the counter's `out` bus every clock, learns the sequence, and flags any sample that is not the previous value plus one (mod 2^WIDTH). It is the self-checking reader for the counter in the SDRAM bring-up benches and in on-board debug, replacing `$monitor` eyeballing with registered pass/fail status and error statistics.

## Interface
- `WIDTH`, 8: width of the observed counter value.
- `LOCK_LEN`, 4: consecutive correct increments required to declare lock (valid range 1..15).
- `ERR_CNT_W`, 16: width of the saturating error counter.

- `clk`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset; clears all state immediately.
- `value`  in  WIDTH: counter output, sampled every rising edge.
- `src_reset`  in  1: the counter's own active-high reset, observed; forces resynchronisation.
- `clear`  in  1: synchronous clear of error statistics.
- `locked`  out  1: sequence tracked and being checked.
- `err_pulse`  out  1: one-cycle strobe per mismatching sample while locked.
- `err_sticky`  out  1: set on first error, held until `clear` or reset.
- `err_count`  out  ERR_CNT_W: number of errors, saturating at all-ones.
- `first_bad`  out  WIDTH: value of the first erroneous sample.
- `first_exp`  out  WIDTH: value expected at the first error.

## Operation
- Reset values: `locked`=0, `err_pulse`=0, `err_sticky`=0, `err_count`=0, `first_bad`=0, `first_exp`=0; state SEEK, `prev`=0, run counter=0.
- `expected` = `prev` + 1, truncated to WIDTH bits (255 -> 0 for WIDTH=8 is a correct increment, not an error).
- SEEK: while `src_reset`=1, stay. First edge with `src_reset`=0: `prev` <= `value`, run <= 0, go to TRAIN.
- TRAIN: `value`==`expected` -> run+1; when run reaches LOCK_LEN, go to LOCKED. Mismatch -> run <= 0, stay in TRAIN, no error reported. `prev` <= `value` every cycle.
- LOCKED: `value`==`expected` -> no action. Mismatch -> `err_pulse`=1, `err_count`+1 (saturating), and if `err_sticky`=0, capture `first_bad`<=`value`, `first_exp`<=`expected` and set `err_sticky`. `prev` <= `value` (resynchronise on the observed value, so a single glitch produces two errors; a stall of N cycles produces N errors).
- `src_reset`=1 in any state -> SEEK on the next edge, `locked` deasserts, run cleared; statistics are kept.
- `clear`=1: `err_count`<=0, `err_sticky`<=0, `first_*`<=0. If an error occurs in the same cycle, the clear wins and the error is then counted: `err_count`=1, sticky set, `first_*` captured.
- `src_reset` and `clear` together: both take effect.
- Async `reset` mid-stream returns everything to the reset values; relock needs 1 + LOCK_LEN samples.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- A sample presented before edge N is judged at edge N; `err_pulse`, `err_count`, `first_*` reflect it after edge N (one-cycle latency).
- `locked` rises after the edge that samples the LOCK_LEN-th correct increment, i.e. LOCK_LEN+1 edges after leaving SEEK.
- `src_reset` high at edge N -> `locked`=0 after edge N.

## Configuration
- `COUNTER_CHECKER_WRAP_EN`: when defined, adds output `wrap_count` (16 bits, reset 0, cleared by `clear`, saturating) that increments on every correct max -> 0 transition sampled in LOCKED. When undefined, the port and its logic do not exist; all other behaviour is identical.

## Structure
- Shared package `counter_checker_pkg`: state enum (SEEK, TRAIN, LOCKED), default widths, LOCK_LEN upper bound.
- One sub-module, `sat_counter` (parameterised width, inc/clear, saturating), used for `err_count` and `wrap_count`.

## Test plan
- Clean ramp: `src_reset` pulse, then value 0,1,2,... -> `locked`=1 after edge 5 (LOCK_LEN=4); no `err_pulse` through 300 samples, including 255 -> 0.
- Glitch: locked at value 20, inject 99 instead of 21, then resume 22 -> two `err_pulse`s, `err_count`=2, `first_bad`=99, `first_exp`=21.
- Stall: locked, hold value at 50 for 3 extra cycles -> `err_count`=3, `first_bad`=50, `first_exp`=51.
- Resync: locked, assert `src_reset` for 2 cycles with value forced to 0, release -> `locked` low, no errors, relock after 5 edges; `err_count` unchanged.
- Saturation/clear: ERR_CNT_W=2, force 5 errors -> `err_count`=3; `clear` together with an error -> `err_count`=1, `err_sticky`=1.
- Async reset while locked with errors -> all outputs 0 immediately, before the next `clk` edge.
